prism_in_cond: RTL

Input conditioning stage placed directly upstream of the PRISM FSM's `in_data[6:0]`. It takes the synchronised `ui_in[6:0]` pins and applies a per-bit glitch filter with a programmable threshold. It captures programmable rising/falling edges of the filtered signals into sticky flags and raises a maskable interrupt. The filtered vector drives the PRISM input bits, so the FSM only sees debounced levels.

---
 rtl/prism_pkg.sv | 15 +
 rtl/prism_glitch_filter.sv | 45 ++++
 rtl/prism_in_cond.sv | 121 ++++++++++++
 3 files changed

// File: rtl/prism_pkg.sv
// Shared constants for the PRISM input conditioning block: register map and
// bit-field offsets used by both the RTL and anything that talks to it.
package prism_pkg;

  // Register select values on cfg_addr
  localparam logic [1:0] PRISM_IN_CTRL  = 2'd0;
  localparam logic [1:0] PRISM_IN_EDGE  = 2'd1;
  localparam logic [1:0] PRISM_IN_FLAGS = 2'd2;
  localparam logic [1:0] PRISM_IN_MASK  = 2'd3;

  // Field offsets inside the 32-bit registers
  localparam int unsigned EDGE_FALL_LSB = 8;
  localparam int unsigned MASK_COND_LSB = 16;

endpackage

// File: rtl/prism_glitch_filter.sv
// One-bit glitch filter: the output level follows the input only after the
// input has differed from it for thresh+1 consecutive samples.
module prism_glitch_filter #(
  parameter int unsigned FILT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic [FILT_BITS-1:0] thresh,
  output logic                 s,
  output logic                 next_s
);

  logic                 s_q;
  logic [FILT_BITS-1:0] c_q, c_d;

  // Next level / counter; >= lets a lowered thresh flip on the next differing sample
  always_comb begin
    next_s = s_q;
    c_d    = c_q;
    if (din == s_q) begin
      c_d = '0;
    end else if (c_q >= thresh) begin
      next_s = din;
      c_d    = '0;
    end else begin
      // c_q < thresh here, so the increment can never wrap
      c_d = c_q + 1'b1;
    end
  end

  // Filter state, cleared by reset (drops any pending transition)
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
      c_q <= '0;
    end else begin
      s_q <= next_s;
      c_q <= c_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/prism_in_cond.sv
// PRISM input conditioning: per-bit glitch filter, edge capture into sticky
// W1C flags and a maskable interrupt. Optional input synchroniser is enabled
// by defining PRISM_IN_COND_SYNC_EN.
module prism_in_cond
  import prism_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned FILT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic [WIDTH-1:0] cond_out,
  output logic             edge_irq
);

  logic [FILT_BITS-1:0] thresh_q;
  logic [WIDTH-1:0]     rise_en_q, fall_en_q, mask_q;
  logic [WIDTH-1:0]     flags_q, flags_d;
  logic [WIDTH-1:0]     filt_in, s, next_s;
  logic [WIDTH-1:0]     rise, fall, flag_set;

`ifdef PRISM_IN_COND_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronously driven pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign filt_in = sync2_q;
`else
  assign filt_in = raw_in;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    prism_glitch_filter #(
      .FILT_BITS(FILT_BITS)
    ) u_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (filt_in[i]),
      .thresh(thresh_q),
      .s     (s[i]),
      .next_s(next_s[i])
    );
  end

  assign rise     = ~s & next_s;
  assign fall     = s & ~next_s;
  assign flag_set = (rise & rise_en_q) | (fall & fall_en_q);

  // Sticky flags: W1C first, then set so a coincident edge wins
  always_comb begin
    flags_d = flags_q;
    if (cfg_wr && (cfg_addr == PRISM_IN_FLAGS)) begin
      flags_d = flags_d & ~cfg_wdata[WIDTH-1:0];
    end
    flags_d = flags_d | flag_set;
  end

  // Configuration registers and flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
      flags_q   <= '0;
    end else begin
      flags_q <= flags_d;
      if (cfg_wr) begin
        case (cfg_addr)
          PRISM_IN_CTRL: thresh_q <= cfg_wdata[FILT_BITS-1:0];
          PRISM_IN_EDGE: begin
            rise_en_q <= cfg_wdata[WIDTH-1:0];
            fall_en_q <= cfg_wdata[EDGE_FALL_LSB +: WIDTH];
          end
          PRISM_IN_MASK: mask_q <= cfg_wdata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      PRISM_IN_CTRL: cfg_rdata[FILT_BITS-1:0] = thresh_q;
      PRISM_IN_EDGE: begin
        cfg_rdata[WIDTH-1:0]              = rise_en_q;
        cfg_rdata[EDGE_FALL_LSB +: WIDTH] = fall_en_q;
      end
      PRISM_IN_FLAGS: cfg_rdata[WIDTH-1:0] = flags_q;
      PRISM_IN_MASK: begin
        cfg_rdata[WIDTH-1:0]              = mask_q;
        cfg_rdata[MASK_COND_LSB +: WIDTH] = s;
      end
      default: ;
    endcase
  end

  assign cond_out = s;
  assign edge_irq = |(flags_q & mask_q);

  // Only some write-data fields are decoded
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

endmodule
